mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle main controller for the MIPS-subset CPU; successor to the single-cycle opcode decoder. Sequences each instruction through IF/ID/EXE/MEM/WB states, stalls on a memory ready handshake with a bounded timeout, and emits per-state datapath controls. It sits between the instruction register and the shared-memory/regfile/ALU datapath, and replaces the single-cycle decoder when the datapath is built in multi-cycle form.

## Interface
- `ALUOP_W`, default 3: width of `alu_op`.
- `TIMEOUT`, default 15: max cycles waiting on `mem_ready` before a bus error.
- clk  in  1  system clock; one clock domain, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  opcode field `IR[31:26]`; valid from the ID cycle onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- zero  in  1  ALU zero flag; used in the beq EXE cycle.
- pc_wr, pc_wr_cond, ir_wr, mem_rd, mem_wr, reg_wr, mem_to_reg, alu_src_a, alu_src_b, ext_op  out  1 each  datapath controls.
- pc_src  out  2  00 ALU (PC+4), 01 branch target, 10 jump target.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- alu_op  out  ALUOP_W  000 add, 001 R-type funct, 010 or, 100 sub.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when an opcode is unsupported.
- bus_err  out  1  one-cycle pulse when a memory access times out.

## Operation
- Supported opcodes: R 000000, ori 001101, addiu 001001, lw 100011, sw 101011, beq 000100, j 000010.
- State encoding: IF 0, ID 1, EXE 2, MEM 3, WB 4. Moore outputs are decoded from the state and `op_q`. All unlisted controls are 0.
- **IF**
  - Outputs: `mem_rd=1`, `alu_src_a=0`, `alu_src_b`=const-4 path, `alu_op=000`, `pc_src=00`.
  - If `mem_ready`: assert `ir_wr=1`, `pc_wr=1`, go to ID. Otherwise stay in IF.
- **ID**
  - Latch `op` into `op_q`. ALU computes the branch target (`alu_op=000`, `ext_op=1`).
  - j: `pc_wr=1`, `pc_src=10`, `instr_done`, go to IF.
  - Unsupported opcode: `illegal_op`, go to IF with no other writes.
  - Otherwise go to EXE.
- **EXE**
  - `alu_src_a=1`.
  - R-type: `alu_op=001`, go to WB.
  - ori: `alu_src_b=1`, `ext_op=0`, `alu_op=010`, go to WB.
  - addiu: `alu_src_b=1`, `ext_op=1`, `alu_op=000`, go to WB.
  - lw/sw: `alu_src_b=1`, `ext_op=1`, `alu_op=000`, go to MEM.
  - beq: `alu_op=100`, `pc_wr_cond=1`, `pc_src=01`; the PC loads only if `zero`. Assert `instr_done`, go to IF.
- **MEM**
  - lw: `mem_rd=1` until `mem_ready`, then go to WB.
  - sw: `mem_wr=1` until `mem_ready`, then `instr_done`, go to IF.
- **WB**
  - `reg_wr=1`.
  - `reg_dst=01` for R-type, else 00.
  - `mem_to_reg=1` for lw only.
  - Assert `instr_done`, go to IF.
- **Wait counter**
  - Counts consecutive IF/MEM cycles with `mem_ready=0`; clears on any state change.
  - When it reaches `TIMEOUT`: pulse `bus_err`, drop `mem_rd`/`mem_wr`, go to IF. No `ir_wr`, `pc_wr` or `reg_wr` is issued.

## Timing
- Reset: state=IF, `op_q`=0, counter=0, all pulses 0. The only output active in the first post-reset cycle is `mem_rd=1`.
- `rst` mid-instruction aborts it the next edge; no partial writes follow.
- Cycles per instruction with `mem_ready` held high: j 2, beq 3, R/ori/addiu 4, sw 4, lw 5. Each cycle of `mem_ready=0` in IF or MEM adds one.
- `mem_ready` is ignored outside IF and MEM.
- `mem_ready` arriving on the same edge as the timeout: `mem_ready` wins and no `bus_err` is raised.
- Counter width is `$clog2(TIMEOUT+1)` and it saturates. Never wraps.
- `instr_done`, `illegal_op` and `bus_err` are mutually exclusive in any cycle.

## Configuration
- `MC_CTRL_JAL_EN` defined: jal (000011) is supported.
  - ID: `pc_wr=1`, `pc_src=10`, go to WB.
  - WB: `reg_wr=1`, `reg_dst=10`, with a PC+4 write-back select (`mem_to_reg=0`, `alu_src_a=0`). Assert `instr_done`.
- Undefined: 000011 is illegal (`illegal_op`), and `reg_dst` never takes value 10.

## Structure
- Package `mc_ctrl_pkg` holds:
  - opcode constants;
  - the state enum;
  - ALUop encodings;
  - `pc_src` and `reg_dst` encodings;
  - the instruction-class enum (R, ORI, ADDIU, LW, SW, BEQ, J, JAL, ILLEGAL).
- Sub-module `mc_op_class` is a combinational opcode-to-class decoder. It honours `MC_CTRL_JAL_EN`. The FSM consumes only its class.

## Test plan
- Reset, then lw with `mem_ready` high → IF, ID, EXE, MEM, WB. WB shows `reg_wr=1`, `mem_to_reg=1`, `reg_dst=00`, with `instr_done` on cycle 5.
- beq, `zero=1` → `pc_wr_cond=1`, `pc_src=01`, `alu_op=100` in cycle 3; `instr_done`. Next cycle is IF.
- sw with `mem_ready` low for 3 MEM cycles → `mem_wr` held 4 cycles, `instr_done` at cycle 7, no `reg_wr`.
- IF with `mem_ready` low for 15 cycles (TIMEOUT=15) → `bus_err` pulse, no `ir_wr`; FSM restarts IF with counter 0.
- op=000011 → without the macro, `illegal_op` in ID and back to IF. With `MC_CTRL_JAL_EN`, ID `pc_wr`/`pc_src=10`, then WB with `reg_dst=10`, total 3 cycles.
- `rst` asserted during an R-type EXE → next cycle state=IF, and no `reg_wr` ever issued for that instruction.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, FSM states,
// ALU operations, PC/register-destination selects and the decoded instruction class.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } mc_state_e;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_FUNCT = 3'b001;
   localparam logic [2:0] ALU_OR    = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b100;

   localparam logic [1:0] PC_SRC_ALU = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

   localparam logic [1:0] REG_DST_RT = 2'b00;
   localparam logic [1:0] REG_DST_RD = 2'b01;
   localparam logic [1:0] REG_DST_RA = 2'b10;

   typedef enum logic [3:0] {
      CL_R,
      CL_ORI,
      CL_ADDIU,
      CL_LW,
      CL_SW,
      CL_BEQ,
      CL_J,
      CL_JAL,
      CL_ILLEGAL
   } mc_class_e;

endpackage

// File: rtl/mc_op_class.sv
// Combinational opcode-to-instruction-class decoder.
// jal is recognised only when MC_CTRL_JAL_EN is defined; otherwise it decodes as illegal.
module mc_op_class
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] op_i,
   output mc_class_e  cls_o
);

   always_comb begin
      cls_o = CL_ILLEGAL;
      case (op_i)
         OP_R:     cls_o = CL_R;
         OP_ORI:   cls_o = CL_ORI;
         OP_ADDIU: cls_o = CL_ADDIU;
         OP_LW:    cls_o = CL_LW;
         OP_SW:    cls_o = CL_SW;
         OP_BEQ:   cls_o = CL_BEQ;
         OP_J:     cls_o = CL_J;
`ifdef MC_CTRL_JAL_EN
         OP_JAL:   cls_o = CL_JAL;
`endif
         default:  cls_o = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller: IF/ID/EXE/MEM/WB sequencing with a bounded mem_ready wait.
// Build option MC_CTRL_JAL_EN adds jal (ID jumps, WB writes PC+4 to $31).
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 3,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         op,
   input  logic               mem_ready,
   input  logic               zero,
   output logic               pc_wr,
   output logic               pc_wr_cond,
   output logic               ir_wr,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic               reg_wr,
   output logic               mem_to_reg,
   output logic               alu_src_a,
   output logic               alu_src_b,
   output logic               ext_op,
   output logic [1:0]         pc_src,
   output logic [1:0]         reg_dst,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               instr_done,
   output logic               illegal_op,
   output logic               bus_err,
   output logic [2:0]         state_dbg,
   output logic               br_taken_dbg
);

   localparam int CW = $clog2(TIMEOUT + 1);

   mc_state_e       state_q, state_d;
   logic [5:0]      op_q, op_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      alu_op_c;
   logic            mem_wait;
   logic            timeout;
   mc_class_e       cls;

   // In ID the opcode is still on the input; from EXE on it comes from op_q.
   mc_op_class u_op_class (
      .op_i  ((state_q == S_ID) ? op : op_q),
      .cls_o (cls)
   );

   assign mem_wait     = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready;
   assign timeout      = mem_wait && (cnt_q == CW'(TIMEOUT - 1));
   assign alu_op       = ALUOP_W'(alu_op_c);
   assign state_dbg    = state_q;
   assign br_taken_dbg = (state_q == S_EXE) && (cls == CL_BEQ) && zero;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      pc_wr      = 1'b0;
      pc_wr_cond = 1'b0;
      ir_wr      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      reg_wr     = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 1'b0;
      ext_op     = 1'b0;
      pc_src     = PC_SRC_ALU;
      reg_dst    = REG_DST_RT;
      alu_op_c   = ALU_ADD;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      bus_err    = 1'b0;

      case (state_q)
         S_IF: begin
            if (timeout) begin
               bus_err = 1'b1;
            end else begin
               mem_rd = 1'b1;
               if (mem_ready) begin
                  ir_wr   = 1'b1;
                  pc_wr   = 1'b1;
                  state_d = S_ID;
               end
            end
         end
         S_ID: begin
            op_d   = op;
            ext_op = 1'b1;
            case (cls)
               CL_J: begin
                  pc_wr      = 1'b1;
                  pc_src     = PC_SRC_JMP;
                  instr_done = 1'b1;
                  state_d    = S_IF;
               end
`ifdef MC_CTRL_JAL_EN
               CL_JAL: begin
                  pc_wr   = 1'b1;
                  pc_src  = PC_SRC_JMP;
                  state_d = S_WB;
               end
`endif
               CL_ILLEGAL: begin
                  illegal_op = 1'b1;
                  state_d    = S_IF;
               end
               default: state_d = S_EXE;
            endcase
         end
         S_EXE: begin
            alu_src_a = 1'b1;
            case (cls)
               CL_R: begin
                  alu_op_c = ALU_FUNCT;
                  state_d  = S_WB;
               end
               CL_ORI: begin
                  alu_src_b = 1'b1;
                  alu_op_c  = ALU_OR;
                  state_d   = S_WB;
               end
               CL_ADDIU: begin
                  alu_src_b = 1'b1;
                  ext_op    = 1'b1;
                  state_d   = S_WB;
               end
               CL_LW, CL_SW: begin
                  alu_src_b = 1'b1;
                  ext_op    = 1'b1;
                  state_d   = S_MEM;
               end
               CL_BEQ: begin
                  alu_op_c   = ALU_SUB;
                  pc_wr_cond = 1'b1;
                  pc_src     = PC_SRC_BR;
                  instr_done = 1'b1;
                  state_d    = S_IF;
               end
               default: state_d = S_IF;
            endcase
         end
         S_MEM: begin
            if (timeout) begin
               bus_err = 1'b1;
               state_d = S_IF;
            end else if (cls == CL_LW) begin
               mem_rd = 1'b1;
               if (mem_ready) state_d = S_WB;
            end else begin
               mem_wr = 1'b1;
               if (mem_ready) begin
                  instr_done = 1'b1;
                  state_d    = S_IF;
               end
            end
         end
         S_WB: begin
            reg_wr     = 1'b1;
            reg_dst    = (cls == CL_R) ? REG_DST_RD : REG_DST_RT;
            mem_to_reg = (cls == CL_LW);
`ifdef MC_CTRL_JAL_EN
            if (cls == CL_JAL) reg_dst = REG_DST_RA;
`endif
            instr_done = 1'b1;
            state_d    = S_IF;
         end
         default: state_d = S_IF;
      endcase

      // Wait counter restarts on any state change and on a timeout retry of IF.
      cnt_d = cnt_q;
      if ((state_d != state_q) || timeout) begin
         cnt_d = '0;
      end else if (mem_wait && (cnt_q != CW'(TIMEOUT))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IF;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: an instruction-level model expands each opcode
// into its expected per-cycle control words, which are queued and compared cycle by cycle.
module tb_mc_control_fsm;

   localparam int T = 15;

`ifdef MC_CTRL_JAL_EN
   localparam bit JAL_EN = 1'b1;
`else
   localparam bit JAL_EN = 1'b0;
`endif

   typedef struct packed {
      logic       pc_wr;
      logic       pc_wr_cond;
      logic       ir_wr;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic       alu_src_b;
      logic       ext_op;
      logic [1:0] pc_src;
      logic [1:0] reg_dst;
      logic [2:0] alu_op;
      logic       instr_done;
      logic       illegal_op;
      logic       bus_err;
   } ctl_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic       mem_ready;
   logic       zero;
   logic       pc_wr, pc_wr_cond, ir_wr, mem_rd, mem_wr, reg_wr, mem_to_reg;
   logic       alu_src_a, alu_src_b, ext_op;
   logic [1:0] pc_src, reg_dst;
   logic [2:0] alu_op;
   logic       instr_done, illegal_op, bus_err;
   logic [2:0] state_dbg;
   logic       br_taken_dbg;
   ctl_t       got;

   logic [19:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   mc_control_fsm #(.ALUOP_W(3), .TIMEOUT(T)) dut (
      .clk          (clk),
      .rst          (rst),
      .op           (op),
      .mem_ready    (mem_ready),
      .zero         (zero),
      .pc_wr        (pc_wr),
      .pc_wr_cond   (pc_wr_cond),
      .ir_wr        (ir_wr),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .reg_wr       (reg_wr),
      .mem_to_reg   (mem_to_reg),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .ext_op       (ext_op),
      .pc_src       (pc_src),
      .reg_dst      (reg_dst),
      .alu_op       (alu_op),
      .instr_done   (instr_done),
      .illegal_op   (illegal_op),
      .bus_err      (bus_err),
      .state_dbg    (state_dbg),
      .br_taken_dbg (br_taken_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   assign got = {pc_wr, pc_wr_cond, ir_wr, mem_rd, mem_wr, reg_wr, mem_to_reg,
                 alu_src_a, alu_src_b, ext_op, pc_src, reg_dst, alu_op,
                 instr_done, illegal_op, bus_err};

   task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got_v, exp_v, $time);
      end
   endtask

   function automatic byte kind(input logic [5:0] o);
      case (o)
         6'b000000: return "R";
         6'b001101: return "O";
         6'b001001: return "A";
         6'b100011: return "L";
         6'b101011: return "S";
         6'b000100: return "B";
         6'b000010: return "J";
         6'b000011: return JAL_EN ? "K" : "X";
         default:   return "X";
      endcase
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] rop();
      return 6'($urandom_range(0, 63));
   endfunction

   // driver: apply one cycle of inputs, compare on the falling edge
   task automatic step(input logic rdy, input logic [5:0] opv, input logic z,
                       input ctl_t e, input logic [2:0] st, input string tag);
      mem_ready = rdy;
      op        = opv;
      zero      = z;
      exp_q.push_back(e);
      @(negedge clk);
      chk({tag, "_ctl"}, 32'(got), 32'(exp_q.pop_front()));
      chk({tag, "_state"}, 32'(state_dbg), 32'(st));
      chk({tag, "_br"}, 32'(br_taken_dbg), 32'(e.pc_wr_cond & z));
      @(posedge clk);
      #1;
   endtask

   // reference model: one instruction with if_w / mem_w cycles of mem_ready low
   task automatic run_instr(input logic [5:0] opc, input logic z, input int if_w, input int mem_w);
      ctl_t e;
      byte  k;
      k = kind(opc);
      for (int c = 0; c <= if_w; c++) begin
         e = '0;
         if (c < if_w) begin
            if (c == T - 1) begin
               e.bus_err = 1'b1;
               step(1'b0, rop(), rb(), e, 3'd0, "if_timeout");
               return;
            end
            e.mem_rd = 1'b1;
            step(1'b0, rop(), rb(), e, 3'd0, "if_wait");
         end else begin
            e.mem_rd = 1'b1;
            e.ir_wr  = 1'b1;
            e.pc_wr  = 1'b1;
            step(1'b1, rop(), rb(), e, 3'd0, "if_fetch");
         end
      end

      e = '0;
      e.ext_op = 1'b1;
      if (k == "J" || k == "K") begin
         e.pc_wr  = 1'b1;
         e.pc_src = 2'b10;
         e.instr_done = (k == "J");
      end else if (k == "X") begin
         e.illegal_op = 1'b1;
      end
      step(rb(), opc, rb(), e, 3'd1, "id");
      if (k == "J" || k == "X") return;

      if (k != "K") begin
         e = '0;
         e.alu_src_a = 1'b1;
         case (k)
            "R": e.alu_op = 3'b001;
            "O": begin e.alu_src_b = 1'b1; e.alu_op = 3'b010; end
            "B": begin
               e.alu_op     = 3'b100;
               e.pc_wr_cond = 1'b1;
               e.pc_src     = 2'b01;
               e.instr_done = 1'b1;
            end
            default: begin e.alu_src_b = 1'b1; e.ext_op = 1'b1; end
         endcase
         step(rb(), rop(), z, e, 3'd2, "exe");
         if (k == "B") return;
      end

      if (k == "L" || k == "S") begin
         for (int c = 0; c <= mem_w; c++) begin
            e = '0;
            if (c < mem_w && c == T - 1) begin
               e.bus_err = 1'b1;
               step(1'b0, rop(), rb(), e, 3'd3, "mem_timeout");
               return;
            end
            e.mem_rd = (k == "L");
            e.mem_wr = (k == "S");
            e.instr_done = (c == mem_w) && (k == "S");
            step(c == mem_w, rop(), rb(), e, 3'd3, "mem");
         end
         if (k == "S") return;
      end

      e = '0;
      e.reg_wr     = 1'b1;
      e.reg_dst    = (k == "R") ? 2'b01 : ((k == "K") ? 2'b10 : 2'b00);
      e.mem_to_reg = (k == "L");
      e.instr_done = 1'b1;
      step(rb(), rop(), rb(), e, 3'd4, "wb");
   endtask

   function automatic int pick_wait();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) return int'($urandom_range(0, 2));
      if (r == 6) return T - 1;
      if (r == 7) return T;
      return int'($urandom_range(3, 5));
   endfunction

   initial begin
      logic [5:0] ops [8];
      ctl_t       e;
      ops = '{6'b000000, 6'b001101, 6'b001001, 6'b100011,
              6'b101011, 6'b000100, 6'b000010, 6'b000011};

      rst = 1'b1;
      mem_ready = 1'b0;
      op = 6'd0;
      zero = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      e = '0;
      e.mem_rd = 1'b1;
      step(1'b0, rop(), 1'b0, e, 3'd0, "reset");

      run_instr(6'b100011, 1'b0, 0, 0);
      run_instr(6'b000100, 1'b1, 0, 0);
      run_instr(6'b000100, 1'b0, 0, 0);
      run_instr(6'b101011, 1'b0, 0, 3);
      run_instr(6'b000000, 1'b0, T, 0);
      run_instr(6'b000000, 1'b0, T - 1, 0);
      run_instr(6'b100011, 1'b0, 0, T);
      run_instr(6'b000011, 1'b0, 0, 0);
      run_instr(6'b111111, 1'b0, 0, 0);

      // reset in the EXE cycle of an R-type: no write-back may follow
      e = '0; e.mem_rd = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
      step(1'b1, rop(), 1'b0, e, 3'd0, "rst_if");
      e = '0; e.ext_op = 1'b1;
      step(1'b1, 6'b000000, 1'b0, e, 3'd1, "rst_id");
      rst = 1'b1;
      e = '0; e.alu_src_a = 1'b1; e.alu_op = 3'b001;
      step(1'b1, rop(), 1'b0, e, 3'd2, "rst_exe");
      rst = 1'b0;
      e = '0; e.mem_rd = 1'b1;
      step(1'b0, rop(), 1'b0, e, 3'd0, "rst_after");
      run_instr(6'b001001, 1'b0, 0, 0);

      for (int i = 0; i < 80; i++) begin
         logic [5:0] o;
         if ($urandom_range(0, 7) == 0) o = rop();
         else o = ops[$urandom_range(0, 7)];
         run_instr(o, rb(), pick_wait(), pick_wait());
      end

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL exp_q_drain got=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
